// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state type and constants for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic {IDLE, MERGE} state_t;
    localparam int WORD_AW = 14;
    localparam logic [3:0] FULL_MASK = 4'hF;
endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: per-lane select between the stored word and new write data
module dmem_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  mask,
    output logic [31:0] merged
);
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter with read-modify-write for partial writes.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise p0 wins ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_AW = WORD_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_adr,
    input  logic [31:0] p0_wdin,
    input  logic [3:0]  p0_wmask,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rd,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_adr,
    input  logic [31:0] p1_wdin,
    input  logic [3:0]  p1_wmask,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rd,
    output logic        dram_we,
    output logic [31:0] dram_adr,
    output logic [31:0] dram_wdin,
    input  logic [31:0] dram_rd
);
    state_t      state, state_nxt;
    logic        p0_wins, sel_we, gnt_any;
    logic [31:0] sel_adr, sel_wdin, merged, merge_word, merge_adr;
    logic [3:0]  sel_mask;

`ifdef DMEM_ARB_RR_EN
    logic last_p1;
    assign p0_wins = ~p1_req | last_p1;
`else
    assign p0_wins = 1'b1;
`endif

    dmem_byte_merge u_merge (
        .old_word (dram_rd),
        .new_word (sel_wdin),
        .mask     (sel_mask),
        .merged   (merged)
    );

    // grant selection, memory port muxing and next-state decision
    always_comb begin
        p0_gnt    = ~rst & (state == IDLE) & p0_req & p0_wins;
        p1_gnt    = ~rst & (state == IDLE) & p1_req & ~p0_gnt;
        gnt_any   = p0_gnt | p1_gnt;
        sel_we    = p1_gnt ? p1_we    : p0_we;
        sel_adr   = p1_gnt ? p1_adr   : p0_adr;
        sel_wdin  = p1_gnt ? p1_wdin  : p0_wdin;
        sel_mask  = p1_gnt ? p1_wmask : p0_wmask;
        dram_we   = (state == MERGE) ? ~rst : gnt_any & sel_we & (sel_mask == FULL_MASK);
        dram_adr  = (state == MERGE) ? merge_adr : {sel_adr[31:MEM_AW+2], sel_adr[MEM_AW+1:0]} & ~32'd3;
        dram_wdin = (state == MERGE) ? merge_word : sel_wdin;
        state_nxt = (state == IDLE && gnt_any && sel_we && sel_mask != 4'h0 && sel_mask != FULL_MASK) ? MERGE : IDLE;
    end

    // state, read-return registers and tie-break pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rd     <= '0;
            p1_rd     <= '0;
`ifdef DMEM_ARB_RR_EN
            last_p1   <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) p0_rd <= dram_rd;
            if (p1_gnt && !p1_we) p1_rd <= dram_rd;
`ifdef DMEM_ARB_RR_EN
            if (gnt_any) last_p1 <= p1_gnt;
`endif
        end
    end

    // capture the merged word and its address for the write-back cycle
    always_ff @(posedge clk) begin
        if (state_nxt == MERGE) begin
            merge_word <= merged;
            merge_adr  <= dram_adr;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MEM_AW, 14, word-address bits decoded by the data memory (64 KB = 2^14 words).
REQ-002 The port list SHALL be as follows; one clock, reset synchronous and active-high:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p0_req/p1_req  in  1  request; held until grant
- p0_we/p1_we  in  1  1=write, 0=read
- p0_adr/p1_adr  in  32  byte address
- p0_wdin/p1_wdin  in  32  write data, lane-aligned
- p0_wmask/p1_wmask  in  4  byte enables; bit i = byte lane i
- p0_gnt/p1_gnt  out  1  one-cycle accept pulse
- p0_rvalid/p1_rvalid  out  1  read data valid pulse
- p0_rd/p1_rd  out  32  read data
- dram_we  out  1  memory write enable
- dram_adr  out  32  memory byte address, bits [1:0] forced 0
- dram_wdin  out  32  memory write data
- dram_rd  in  32  memory asynchronous read data

Function
REQ-003 The FSM SHALL have two states, IDLE and MERGE.
REQ-004 Grants SHALL be issued only in IDLE, combinationally from req, at most one port per cycle.
REQ-005 A requester SHALL hold req, we, adr, wdin and wmask stable until its gnt; gnt high SHALL mean the request was consumed that cycle.
REQ-006 Read granted in cycle N: dram_adr is driven in N, dram_rd is registered at the end of N, and px_rvalid pulses in N+1 with px_rd equal to that word.
REQ-007 px_rd SHALL hold its last value when rvalid is low.
REQ-008 Write with wmask=4'hF granted in N: dram_we=1 and dram_wdin=wdin in N; the write lands at the end of N; the FSM stays in IDLE.
REQ-009 Partial write (wmask not 0 and not F) granted in N:
- N: dram_we=0, old word read
- the merged word (masked lanes from wdin, others from dram_rd) and the address are latched; go to MERGE
- N+1: dram_we=1 with the latched word and address; return to IDLE
REQ-010 In MERGE, no gnt SHALL be issued regardless of req.
REQ-011 A write with wmask=0 SHALL be granted, cause no memory write and produce no rvalid.
REQ-012 Writes SHALL never produce rvalid.
REQ-013 dram_we SHALL be 0 in every cycle not named in REQ-008/REQ-009.
REQ-014 Address bits above MEM_AW+1 SHALL be forwarded unchanged; aliasing is the memory's behaviour.
REQ-015 A read granted the cycle after a write to the same word SHALL return the new data.

Reset
REQ-016 While rst=1 at a clock edge: state=IDLE, all gnt/rvalid=0, p0_rd=p1_rd=0, dram_we=0, last-grant pointer=p1.
REQ-017 Reset asserted in MERGE SHALL drop the pending merged write; dram_we=0 in the reset cycle.
REQ-018 No gnt SHALL be issued in a cycle where rst=1.

Configuration
REQ-019 Macro DMEM_ARB_RR_EN defined: on simultaneous requests, the port not granted last wins; the pointer updates on every grant.
REQ-020 Macro DMEM_ARB_RR_EN undefined: p0 always wins ties; the pointer logic is absent.
REQ-021 A single requester SHALL be granted immediately in IDLE in both configurations.

Structure
REQ-022 Package dmem_arb_pkg SHALL hold the state enum (IDLE, MERGE), the word-address width constant and the full-mask constant 4'hF.
REQ-023 Lane merging SHALL live in a combinational sub-module dmem_byte_merge (old word, new word, mask -> merged word).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- p0 full write adr 0x10 data 0xDEADBEEF; next cycle p1 read 0x10 -> p1_gnt in the read cycle; p1_rvalid next cycle with p1_rd=0xDEADBEEF.
- Mem[0x20]=0x11223344; p0 write mask 4'b0010 data 0x0000AA00 -> MERGE one cycle, dram_we only in the second cycle; later read returns 0x1122AA44.
- Both req every cycle, reads, RR_EN defined -> grants p0,p1,p0,p1; RR_EN undefined -> p0 every cycle, p1 starved.
- Partial write granted with p1_req high -> p1_gnt=0 in MERGE, p1_gnt=1 in the following IDLE cycle.
- rst in MERGE (mask 4'b0001 to 0x30, old 0x0) -> dram_we never 1; Mem[0x30] stays 0x0; all outputs 0 next cycle.
- p1 write mask 0 to 0x40 -> p1_gnt=1, no dram_we, no rvalid.
